waveform_to_pipe_fifo: RTL and testbench

- Sim-side recorder for 32-bit IEEE-754 samples (spindle rates, force, EMG). Produces the 16-bit word stream that okBTPipeOut reads.
- It is the host-bound counterpart of the BRAM waveform player fed by okBTPipeIn. That block unpacks 16-bit pipe words into 32-bit samples; this one packs 32-bit samples into 16-bit pipe words.
- Runs entirely on ti_clk. The upstream sim_clk-derived strobe arrives already synchronized as a one-cycle pulse.

---
 rtl/waveform_to_pipe_fifo_if.sv | 25 ++
 rtl/waveform_to_pipe_fifo.sv | 134 +++++++++++++
 tb/tb_waveform_to_pipe_fifo.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/waveform_to_pipe_fifo_if.sv
// Sample-in / pipe-word-out handshake bundle between the sim-side recorder
// and the okBTPipeOut endpoint logic.
interface waveform_to_pipe_fifo_if;
  logic        sample_stb;
  logic [31:0] sample_data;
  logic        pipe_out_read;
  logic [15:0] pipe_out_data;
  logic        pipe_out_ready;

  modport master (
    output sample_stb,
    output sample_data,
    output pipe_out_read,
    input  pipe_out_data,
    input  pipe_out_ready
  );

  modport slave (
    input  sample_stb,
    input  sample_data,
    input  pipe_out_read,
    output pipe_out_data,
    output pipe_out_ready
  );
endinterface

// File: rtl/waveform_to_pipe_fifo.sv
// Packs 32-bit samples into a BRAM FIFO and presents them as a first-word-fall-through
// stream of 16-bit pipe words (low half first) for okBTPipeOut.
module waveform_to_pipe_fifo #(
  parameter int AW            = 10,
  parameter int BLOCK_ENTRIES = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  waveform_to_pipe_fifo_if.slave bus,
  output logic [AW:0]            fill_level,
  output logic                   empty,
  output logic                   full,
  output logic [15:0]            overflow_cnt,
  output logic                   underflow
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] BLOCK_L = (AW+1)'(BLOCK_ENTRIES);

  logic [31:0]   mem [DEPTH];
  logic [31:0]   rd_data_q;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_addr_d;
  logic          hsel_q, hsel_d;
  logic [AW:0]   level_q, level_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          ready_q, ready_d;
  logic [15:0]   ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [31:0]   head_q, head_d;
  logic          fwd_q, fwd_d;
  logic [31:0]   fwd_data_q, fwd_data_d;

  logic          wr_acc;
  logic          wr_en;
  logic          rd_ok;
  logic          pop;
  logic [31:0]   next_entry;

  always_comb begin
    wr_acc = bus.sample_stb && !full_q;
    wr_en  = wr_acc && !reset;
    rd_ok  = bus.pipe_out_read && !empty_q;
    pop    = rd_ok && hsel_q;

    // The RAM read issued last edge misses a write landing on the same address
    // that edge; the forwarding register supplies that value instead.
    next_entry = fwd_q ? fwd_data_q : rd_data_q;

    wr_ptr_d = wr_ptr_q + (wr_acc ? AW'(1) : AW'(0));
    rd_ptr_d = rd_ptr_q + (pop ? AW'(1) : AW'(0));
    hsel_d   = hsel_q ^ rd_ok;

    level_d = level_q;
    if (wr_acc && !pop) begin
      level_d = level_q + (AW+1)'(1);
    end else if (pop && !wr_acc) begin
      level_d = level_q - (AW+1)'(1);
    end

    // Head always holds the entry at rd_ptr whenever the FIFO is non-empty.
    head_d = head_q;
    if (pop) begin
      head_d = (level_q == (AW+1)'(1)) ? bus.sample_data : next_entry;
    end else if (empty_q && wr_acc) begin
      head_d = bus.sample_data;
    end

    empty_d = (level_d == '0);
    full_d  = (level_d == DEPTH_L);
    ready_d = (level_q >= BLOCK_L);

    ovf_d = ovf_q;
    if (bus.sample_stb && full_q && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end
    unf_d = unf_q | (bus.pipe_out_read && empty_q);

    // Prefetch the entry behind the next head so a pop never waits on the RAM.
    rd_addr_d  = (reset ? '0 : rd_ptr_d) + AW'(1);
    fwd_d      = wr_en && (wr_ptr_q == rd_addr_d);
    fwd_data_d = bus.sample_data;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= bus.sample_data;
    end
    rd_data_q <= mem[rd_addr_d];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      hsel_q     <= 1'b0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ready_q    <= 1'b0;
      ovf_q      <= '0;
      unf_q      <= 1'b0;
      head_q     <= '0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      hsel_q     <= hsel_d;
      level_q    <= level_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      ready_q    <= ready_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      head_q     <= head_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  assign bus.pipe_out_data  = empty_q ? 16'h0000 : (hsel_q ? head_q[31:16] : head_q[15:0]);
  assign bus.pipe_out_ready = ready_q;
  assign fill_level         = level_q;
  assign empty              = empty_q;
  assign full               = full_q;
  assign overflow_cnt       = ovf_q;
  assign underflow          = unf_q;

endmodule

// File: tb/tb_waveform_to_pipe_fifo.sv
// Randomized bench for waveform_to_pipe_fifo, checked against a queue-based model
// of the FIFO's entries, half-select and status counters.
module tb_waveform_to_pipe_fifo;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int BLOCK = 256;

  logic          clk;
  logic          reset;
  logic [AW:0]   fill_level;
  logic          empty;
  logic          full;
  logic [15:0]   overflow_cnt;
  logic          underflow;

  waveform_to_pipe_fifo_if bus ();

  waveform_to_pipe_fifo #(.AW(AW), .BLOCK_ENTRIES(BLOCK)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .fill_level   (fill_level),
    .empty        (empty),
    .full         (full),
    .overflow_cnt (overflow_cnt),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors;
  int          errors;
  logic [31:0] mq[$];
  bit          mh;
  int          m_ovf;
  bit          m_unf;
  bit          m_ready;

  function automatic logic [15:0] exp_word();
    logic [31:0] e;
    if (mq.size() == 0) return 16'h0000;
    e = mq[0];
    return mh ? e[31:16] : e[15:0];
  endfunction

  // One clock with the given inputs; the model follows the same edge.
  task automatic step(input bit stb, input logic [31:0] d, input bit rd);
    int lvl_prev;
    bus.sample_stb    = stb;
    bus.sample_data   = d;
    bus.pipe_out_read = rd;
    @(posedge clk);
    #1;
    lvl_prev = mq.size();
    m_ready  = (lvl_prev >= BLOCK);
    if (rd) begin
      if (lvl_prev == 0) m_unf = 1'b1;
      else if (!mh) mh = 1'b1;
      else begin
        void'(mq.pop_front());
        mh = 1'b0;
      end
    end
    if (stb) begin
      if (lvl_prev == DEPTH) begin
        if (m_ovf < 65535) m_ovf++;
      end else begin
        mq.push_back(d);
      end
    end
    bus.sample_stb    = 1'b0;
    bus.pipe_out_read = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.sample_stb    = 1'b0;
    bus.pipe_out_read = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
    mh = 1'b0; m_ovf = 0; m_unf = 1'b0; m_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (fill_level !== '0) begin errors++; $display("FAIL reset_level got %0d want 0", fill_level); end
    vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    vectors++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    vectors++; if (bus.pipe_out_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.pipe_out_ready); end
    vectors++; if (bus.pipe_out_data !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", bus.pipe_out_data); end
    vectors++; if (overflow_cnt !== 16'h0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_cnt got ovf=%0d unf=%b want 0/0", overflow_cnt, underflow); end
  endtask

  task automatic test_single();
    do_reset();
    step(1'b1, 32'h3F80_0000, 1'b0);
    vectors++; if (fill_level !== 11'd1) begin errors++; $display("FAIL single_level1 got %0d want 1", fill_level); end
    vectors++; if (bus.pipe_out_data !== 16'h0000) begin errors++; $display("FAIL single_lo got %h want 0000", bus.pipe_out_data); end
    step(1'b0, 32'h0, 1'b1);
    vectors++; if (bus.pipe_out_data !== 16'h3F80) begin errors++; $display("FAIL single_hi got %h want 3f80", bus.pipe_out_data); end
    vectors++; if (fill_level !== 11'd1) begin errors++; $display("FAIL single_halfread_level got %0d want 1", fill_level); end
    step(1'b0, 32'h0, 1'b1);
    vectors++; if (fill_level !== 11'd0 || empty !== 1'b1) begin errors++; $display("FAIL single_drained got level=%0d empty=%b want 0/1", fill_level, empty); end
    vectors++; if (underflow !== 1'b0) begin errors++; $display("FAIL single_unf got %b want 0", underflow); end
  endtask

  task automatic test_block();
    logic [15:0] w;
    do_reset();
    for (int i = 0; i < BLOCK; i++) begin
      step(1'b1, 32'(i), 1'b0);
      vectors++; if (bus.pipe_out_ready !== m_ready) begin errors++; $display("FAIL block_ready_fill[%0d] got %b want %b", i, bus.pipe_out_ready, m_ready); end
    end
    step(1'b0, 32'h0, 1'b0);
    vectors++; if (bus.pipe_out_ready !== 1'b1) begin errors++; $display("FAIL block_ready_up got %b want 1", bus.pipe_out_ready); end
    for (int i = 0; i < 2 * BLOCK; i++) begin
      w = (i % 2 == 0) ? 16'(i / 2) : 16'h0000;
      vectors++; if (bus.pipe_out_data !== w) begin errors++; $display("FAIL block_word[%0d] got %h want %h", i, bus.pipe_out_data, w); end
      step(1'b0, 32'h0, 1'b1);
      vectors++; if (bus.pipe_out_ready !== m_ready) begin errors++; $display("FAIL block_ready_drain[%0d] got %b want %b", i, bus.pipe_out_ready, m_ready); end
    end
    vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL block_empty got %b want 1", empty); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH + 6; i++) begin
      step(1'b1, $urandom, 1'b0);
      vectors++; if (full !== (mq.size() == DEPTH)) begin errors++; $display("FAIL ovf_full[%0d] got %b want %b", i, full, mq.size() == DEPTH); end
      vectors++; if (overflow_cnt !== 16'(m_ovf)) begin errors++; $display("FAIL ovf_cnt[%0d] got %0d want %0d", i, overflow_cnt, m_ovf); end
    end
    vectors++; if (overflow_cnt !== 16'd6) begin errors++; $display("FAIL ovf_final got %0d want 6", overflow_cnt); end
    for (int i = 0; i < 2 * DEPTH; i++) begin
      vectors++; if (bus.pipe_out_data !== exp_word()) begin errors++; $display("FAIL ovf_word[%0d] got %h want %h", i, bus.pipe_out_data, exp_word()); end
      step(1'b0, 32'h0, 1'b1);
    end
    vectors++; if (fill_level !== '0) begin errors++; $display("FAIL ovf_drained got %0d want 0", fill_level); end
  endtask

  task automatic test_wrap();
    int n_wr[2] = '{1000, 100};
    do_reset();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < n_wr[p]; i++) step(1'b1, $urandom, 1'b0);
      vectors++; if (fill_level !== 11'(n_wr[p])) begin errors++; $display("FAIL wrap_level[%0d] got %0d want %0d", p, fill_level, n_wr[p]); end
      for (int i = 0; i < 2 * n_wr[p]; i++) begin
        vectors++; if (bus.pipe_out_data !== exp_word()) begin errors++; $display("FAIL wrap_word[%0d][%0d] got %h want %h", p, i, bus.pipe_out_data, exp_word()); end
        step(1'b0, 32'h0, 1'b1);
      end
    end
    vectors++; if (fill_level !== '0 || empty !== 1'b1) begin errors++; $display("FAIL wrap_end got level=%0d empty=%b want 0/1", fill_level, empty); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 200; i++) begin
      vectors++; if (bus.pipe_out_data !== exp_word()) begin errors++; $display("FAIL b2b_word[%0d] got %h want %h", i, bus.pipe_out_data, exp_word()); end
      step(i % 2 == 0, $urandom, 1'b1);
      vectors++; if (fill_level < 11'd9 || fill_level > 11'd11) begin errors++; $display("FAIL b2b_level[%0d] got %0d want 9..11", i, fill_level); end
    end
  endtask

  task automatic test_random();
    int pw, pr;
    do_reset();
    for (int i = 0; i < 4500; i++) begin
      pw = (i < 2700) ? 75 : 20;
      pr = (i < 2700) ? 40 : 90;
      vectors++; if (bus.pipe_out_data !== exp_word()) begin errors++; $display("FAIL rnd_word[%0d] got %h want %h", i, bus.pipe_out_data, exp_word()); end
      step($urandom_range(99) < pw, $urandom, $urandom_range(99) < pr);
      vectors++;
      if (fill_level !== 11'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH) ||
          bus.pipe_out_ready !== m_ready || overflow_cnt !== 16'(m_ovf) || underflow !== m_unf) begin
        errors++;
        $display("FAIL rnd_status[%0d] got lvl=%0d e=%b f=%b rdy=%b ovf=%0d unf=%b want lvl=%0d e=%b f=%b rdy=%b ovf=%0d unf=%b",
                 i, fill_level, empty, full, bus.pipe_out_ready, overflow_cnt, underflow,
                 mq.size(), mq.size() == 0, mq.size() == DEPTH, m_ready, m_ovf, m_unf);
      end
    end
  endtask

  task automatic test_underflow_reset();
    logic [31:0] s;
    do_reset();
    vectors++; if (bus.pipe_out_data !== 16'h0000) begin errors++; $display("FAIL unf_data got %h want 0000", bus.pipe_out_data); end
    step(1'b0, 32'h0, 1'b1);
    vectors++; if (underflow !== 1'b1 || fill_level !== '0) begin errors++; $display("FAIL unf_set got unf=%b lvl=%0d want 1/0", underflow, fill_level); end
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
    do_reset();
    vectors++; if (fill_level !== '0 || empty !== 1'b1 || underflow !== 1'b0 || overflow_cnt !== 16'h0) begin
      errors++; $display("FAIL midreset got lvl=%0d e=%b unf=%b ovf=%0d want 0/1/0/0", fill_level, empty, underflow, overflow_cnt); end
    s = $urandom;
    step(1'b1, s, 1'b0);
    vectors++; if (bus.pipe_out_data !== s[15:0]) begin errors++; $display("FAIL post_reset_lo got %h want %h", bus.pipe_out_data, s[15:0]); end
    step(1'b0, 32'h0, 1'b1);
    vectors++; if (bus.pipe_out_data !== s[31:16]) begin errors++; $display("FAIL post_reset_hi got %h want %h", bus.pipe_out_data, s[31:16]); end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    reset   = 1'b1;
    bus.sample_stb    = 1'b0;
    bus.sample_data   = 32'h0;
    bus.pipe_out_read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_block();
    test_overflow();
    test_wrap();
    test_back_to_back();
    test_random();
    test_underflow_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
